// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus: decode-stage instruction fields, IX branch
// status and parser ownership in; stall/bubble/flush/write-back controls out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             srec_parse;
    logic             dec_valid;
    logic [4:0]       dec_rs;
    logic [4:0]       dec_rt;
    logic             dec_uses_rs;
    logic             dec_uses_rt;
    logic [4:0]       dec_dest;
    logic             dec_writes;
    logic             dec_is_load;
    logic             exe_branch_taken;
    logic             stall;
    logic             id_ix_bubble;
    logic             flush_if_id;
    logic             wb_write_enable;
    logic [4:0]       wb_dest;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: presents the decoded instruction, consumes controls
    modport master (
        output srec_parse, dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt,
               dec_dest, dec_writes, dec_is_load, exe_branch_taken,
        input  stall, id_ix_bubble, flush_if_id, wb_write_enable, wb_dest,
               stall_count
    );

    // Controller side
    modport slave (
        input  srec_parse, dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt,
               dec_dest, dec_writes, dec_is_load, exe_branch_taken,
        output stall, id_ix_bubble, flush_if_id, wb_write_enable, wb_dest,
               stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the 5-stage core. A shadow scoreboard tracks in-flight
// register writes (IX..WB); RAW hazards against the decode instruction stall
// IF/ID and bubble ID/IX. The pipeline is frozen while the SREC parser owns
// instruction memory, with one flush cycle at the hand-off.
// Build option: define HAZARD_FORWARD_EN when the datapath forwards from MEM
// and WB; only load-use against IX then stalls.
module pipeline_hazard_ctrl #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_RUN} state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] d;
        logic       ld;
    } sb_ent_t;

    state_t                  state_q, state_d;
    sb_ent_t [DEPTH-1:0]     sb_q, sb_d;
    logic    [CNT_W-1:0]     cnt_q, cnt_d;
    logic                    rs_hit, rt_hit, haz;
    logic                    stall_c, bubble_c, flush_c;

    // Source-register match against in-flight destinations
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
`ifdef HAZARD_FORWARD_EN
        // MEM/WB results are forwarded; only a load still in IX is unavailable
        rs_hit = sb_q[0].v & sb_q[0].ld & (sb_q[0].d == bus.dec_rs);
        rt_hit = sb_q[0].v & sb_q[0].ld & (sb_q[0].d == bus.dec_rt);
`else
        // WB is included: the register file only commits at the clock edge
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_q[i].v && (sb_q[i].d == bus.dec_rs)) rs_hit = 1'b1;
            if (sb_q[i].v && (sb_q[i].d == bus.dec_rt)) rt_hit = 1'b1;
        end
`endif
        haz = bus.dec_valid &
              ((bus.dec_uses_rs & (bus.dec_rs != 5'd0) & rs_hit) |
               (bus.dec_uses_rt & (bus.dec_rt != 5'd0) & rt_hit));
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_LOAD;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (!bus.srec_parse) state_d = S_DRAIN;
            S_DRAIN: state_d = S_RUN;
            S_RUN:   if (bus.srec_parse) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // FSM outputs; a taken branch overrides a hazard so the redirect proceeds
    always_comb begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        flush_c  = 1'b0;
        case (state_q)
            S_LOAD: ;
            S_DRAIN: flush_c = 1'b1;
            S_RUN: begin
                if (bus.exe_branch_taken) begin
                    stall_c = 1'b0;
                    flush_c = 1'b1;
                end else begin
                    stall_c  = haz;
                    bubble_c = haz;
                end
            end
            default: ;
        endcase
    end

    // Scoreboard shift toward WB and saturating stall counter
    always_comb begin
        sb_d[0] = '0;
        if (!bubble_c) begin
            sb_d[0].v  = bus.dec_valid & bus.dec_writes & (bus.dec_dest != 5'd0);
            sb_d[0].d  = bus.dec_dest;
            sb_d[0].ld = bus.dec_is_load;
        end
        for (int i = 1; i < DEPTH; i++) sb_d[i] = sb_q[i-1];

        cnt_d = cnt_q;
        if ((state_q == S_RUN) && stall_c && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Scoreboard and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall           = stall_c;
    assign bus.id_ix_bubble    = bubble_c;
    assign bus.flush_if_id     = flush_c;
    assign bus.wb_write_enable = sb_q[DEPTH-1].v;
    assign bus.wb_dest         = sb_q[DEPTH-1].d;
    assign bus.stall_count     = cnt_q;
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage processor (IF, ID, IX, MEM, WB).
- Sequences the fetch, IF/ID and ID/IX pipeline registers by tracking in-flight register-file destinations in a shadow scoreboard, and detects RAW hazards against the instruction in decode.
- Generates stall, bubble and flush controls, and gates the register-file write enable.
- Holds the pipeline frozen while the SREC parser owns instruction memory.

Parameters:
- DEPTH, 3, number of stages between decode output and register-file write (IX, MEM, WB); scoreboard entries.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- srec_parse  in  1  SREC parser active; the pipeline must stay frozen
- dec_valid  in  1  instruction in ID is valid (not a bubble)
- dec_rs  in  5  ID source register 1
- dec_rt  in  5  ID source register 2
- dec_uses_rs  in  1  ID instruction reads rs
- dec_uses_rt  in  1  ID instruction reads rt
- dec_dest  in  5  ID destination register
- dec_writes  in  1  ID instruction writes the register file
- dec_is_load  in  1  ID instruction is a load
- exe_branch_taken  in  1  branch/jump resolved taken in IX this cycle
- stall  out  1  hold PC and IF/ID (combinational)
- id_ix_bubble  out  1  load a NOP into ID/IX instead of the decoded instruction
- flush_if_id  out  1  invalidate IF/ID contents
- wb_write_enable  out  1  register-file write enable for the WB-stage instruction
- wb_dest  out  5  register-file write address for WB
- stall_count  out  CNT_W  saturating count of cycles with stall=1 in RUN

Behaviour:
- Reset (async, rst=1): state=LOAD, all scoreboard entries invalid, stall_count=0. Outputs during reset: stall=1, id_ix_bubble=1, flush_if_id=0, wb_write_enable=0, wb_dest=0.
- Scoreboard: DEPTH entries of {valid, dest, is_load}. Entry 0 is IX and entry DEPTH-1 is WB. Each clk every entry shifts one stage toward WB, and the WB entry retires.
- Entry 0 load value: {dec_valid & dec_writes & (dec_dest!=0), dec_dest, dec_is_load}. It loads an invalid entry instead when id_ix_bubble=1.
- wb_write_enable = valid of entry DEPTH-1; wb_dest = its dest. Both are registered values.
- FSM states:
  - LOAD: stall=1, id_ix_bubble=1, scoreboard shifts in invalid entries, counter frozen. Go to DRAIN when srec_parse=0.
  - DRAIN: exactly one cycle with stall=1 and flush_if_id=1. This discards the stale IF/ID word fetched at the parser hand-off. Then go to RUN.
  - RUN: normal operation. srec_parse=1 forces LOAD on the next clk.
- Hazard in RUN (no forwarding): haz is true when dec_valid, and (dec_uses_rs and dec_rs!=0 matches any valid entry dest) or (dec_uses_rt and dec_rt!=0 matches any valid entry dest). This includes the WB entry, because the register file writes at the clock edge.
- RUN outputs: stall = haz; id_ix_bubble = haz | exe_branch_taken.
- Branch: exe_branch_taken=1 gives flush_if_id=1 and id_ix_bubble=1 for one cycle, and forces stall=0 so the fetch redirect proceeds. Branch has priority over hazard in the same cycle.
- Register $0 never causes a hazard and never creates a valid entry.
- stall_count increments on each RUN cycle with stall=1 and saturates at 2^CNT_W-1 (no wrap).
- srec_parse rising mid-hazard: the next state is LOAD and the scoreboard drains naturally. In-flight writes still retire in order through WB.

Optional Feature:
- Macro HAZARD_FORWARD_EN.
- When defined, the datapath forwards from MEM and WB. A hazard is then raised only for load-use: a source register matches entry 0 with valid=1 and is_load=1. This produces exactly a one-cycle stall plus bubble.
- When undefined, the full scoreboard compare described above applies (up to DEPTH stall cycles).
- Reset, FSM and branch behaviour are identical in both builds.

Test Plan:
- Reset, then srec_parse=1 for 10 cycles, then 0 → stall=1 throughout LOAD; one DRAIN cycle with flush_if_id=1; RUN on the next cycle with stall=0; stall_count=0.
- Write $5 then immediately read $5 (no forwarding build) → stall=1 for 3 cycles, id_ix_bubble=1 in those cycles, wb_write_enable=1 with wb_dest=5 on the last; stall_count=3.
- Write $0 then read $0 → stall never asserts; wb_write_enable stays 0.
- Hazard on $7 coincident with exe_branch_taken=1 → that cycle stall=0, flush_if_id=1, id_ix_bubble=1; no stall on the following cycle if the flushed reader is gone.
- HAZARD_FORWARD_EN: load to $3 then read $3 → exactly 1 stall cycle; ALU write to $3 then read $3 → 0 stall cycles.
- Force a continuous hazard with CNT_W=4 for 20 cycles → stall_count saturates at 15.
